// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, driver FSM state type and command-word sizing
// shared by the ALU driver slice.
package alu_pkg;

    localparam logic [4:0] ALUOP_ADD = 5'b00000;
    localparam logic [4:0] ALUOP_SUB = 5'b00001;

    // Queued command payload without tag: {op[4:0], a[31:0], b[31:0]}.
    localparam int CMD_W = 69;

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, RESP} drv_state_t;

    function automatic logic op_supported(input logic [4:0] op);
        return (op == ALUOP_ADD) || (op == ALUOP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with full/empty flags and
// asynchronous active-low reset. DEPTH must be a power of two, >= 2.
module alu_cmd_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/alu_driver.sv
// alu_driver: queues tagged ALU requests, issues them one at a time to the
// registered ALU and returns tagged results. Optional ALU_DRV_SELFCHECK_EN.
module alu_driver
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [4:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       alu_op,
    input  logic [31:0]      alu_c,
    input  logic [7:0]       alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_c,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_DRV_SELFCHECK_EN
    ,
    output logic             rsp_mismatch
`endif
);

    drv_state_t             state;
    drv_state_t             nstate;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [CMD_W+TAG_W-1:0] head;
    logic [TAG_W-1:0]       h_tag;
    logic [4:0]             h_op;
    logic [31:0]            h_a;
    logic [31:0]            h_b;
    logic [TAG_W-1:0]       tag_q;
    logic                   zero_unused;

    assign req_ready   = !full;
    assign zero_unused = &alu_zero[7:1];

    alu_cmd_fifo #(
        .WIDTH(CMD_W + TAG_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (req_valid && req_ready),
        .wdata({req_tag, req_op, req_a, req_b}),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    assign {h_tag, h_op, h_a, h_b} = head;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        pop    = 1'b0;
        unique case (state)
            IDLE: if (!empty) begin
                pop    = 1'b1;
                nstate = op_supported(h_op) ? WAIT : RESP;
            end
            WAIT: nstate = CAPT;
            CAPT: nstate = RESP;
            RESP: if (rsp_ready) nstate = IDLE;
        endcase
    end

`ifdef ALU_DRV_SELFCHECK_EN
    logic [31:0] exp_c;
    assign exp_c = (alu_op == ALUOP_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);
`endif

    // Unsupported ops skip the ALU entirely and answer straight from IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= ALUOP_ADD;
            tag_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_c     <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_tag   <= '0;
`ifdef ALU_DRV_SELFCHECK_EN
            rsp_mismatch <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (pop) begin
                    if (op_supported(h_op)) begin
                        alu_a  <= h_a;
                        alu_b  <= h_b;
                        alu_op <= h_op;
                        tag_q  <= h_tag;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_c     <= '0;
                        rsp_zero  <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_tag   <= h_tag;
`ifdef ALU_DRV_SELFCHECK_EN
                        rsp_mismatch <= 1'b0;
`endif
                    end
                end
                WAIT: ;
                CAPT: begin
                    rsp_valid <= 1'b1;
                    rsp_c     <= alu_c;
                    rsp_zero  <= alu_zero[0];
                    rsp_err   <= 1'b0;
                    rsp_tag   <= tag_q;
`ifdef ALU_DRV_SELFCHECK_EN
                    rsp_mismatch <= (alu_c != exp_c) || (alu_zero[0] != (exp_c == '0));
`endif
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: randomized and directed bench for alu_driver with a registered
// ALU model and a queue-based reference of expected responses.
module tb_alu_driver;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [4:0]       req_op = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [4:0]       alu_op;
    logic [31:0]      alu_c = '0;
    logic [7:0]       alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_c;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
`ifdef ALU_DRV_SELFCHECK_EN
    logic             rsp_mismatch;
`endif

    alu_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
`ifdef ALU_DRV_SELFCHECK_EN
        , .rsp_mismatch(rsp_mismatch)
`endif
    );

    always #5 clk = ~clk;

    // Registered ALU; alu_fault makes it return C+1.
    logic alu_fault = 1'b0;
    always @(posedge clk)
        alu_c <= ((alu_op == 5'd1) ? (alu_a - alu_b) : (alu_a + alu_b)) + {31'b0, alu_fault};
    assign alu_zero = {7'b0, alu_c == 32'd0};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    typedef struct {
        logic [31:0]      c;
        logic             z;
        logic             err;
        logic [TAG_W-1:0] tag;
        logic             mm;
    } exp_t;

    exp_t q[$];

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] op, input logic [TAG_W-1:0] tag,
                                   input logic flt);
        exp_t   e;
        longint s;
        e.tag = tag;
        e.err = !(op == 5'd0 || op == 5'd1);
        if (e.err) begin
            e.c  = '0;
            e.z  = 1'b0;
            e.mm = 1'b0;
        end else begin
            if (op == 5'd0) s = longint'(signed'(a)) + longint'(signed'(b));
            else            s = longint'(signed'(a)) - longint'(signed'(b));
            e.c  = 32'(s) + {31'b0, flt};
            e.z  = (e.c == 32'd0);
            e.mm = flt;
        end
        return e;
    endfunction

    // Monitor: scores responses against the model queue and checks hold-while-stalled.
    logic             stall_prev = 1'b0;
    logic [31:0]      c_prev;
    logic [TAG_W-1:0] tag_prev;
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", rsp_valid, 1);
                check("hold_c", rsp_c, c_prev);
                check("hold_tag", rsp_tag, tag_prev);
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    check("rsp_c", rsp_c, e.c);
                    check("rsp_zero", rsp_zero, e.z);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_tag", rsp_tag, e.tag);
`ifdef ALU_DRV_SELFCHECK_EN
                    check("rsp_mismatch", rsp_mismatch, e.mm);
`endif
                end
            end
            if (req_valid && req_ready) q.push_back(model(req_a, req_b, req_op, req_tag, alu_fault));
            stall_prev = rsp_valid && !rsp_ready;
            c_prev     = rsp_c;
            tag_prev   = rsp_tag;
        end
    end

    logic rnd_ready = 1'b0;
    initial forever begin
        @(posedge clk); #1;
        if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic [TAG_W-1:0] tag);
        int k = 0;
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && k < 100) begin @(negedge clk); k++; end
        if (!req_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((q.size() != 0 || rsp_valid) && k < 500) begin @(posedge clk); #1; k++; end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rsp_valid"}, rsp_valid, 0);
        check({pfx, "_rsp_c"}, rsp_c, 0);
        check({pfx, "_rsp_tag"}, rsp_tag, 0);
        check({pfx, "_rsp_err"}, rsp_err, 0);
        check({pfx, "_alu_a"}, alu_a, 0);
        check({pfx, "_alu_op"}, alu_op, 0);
        check({pfx, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        int          n;
        int          acc;
        logic [4:0]  op_save;
        logic [31:0] a_save;
        logic [31:0] ra;

        #1 rstn = 1'b0;
        #2 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // ADD 5+7 with latency measured from the push edge
        rsp_ready = 1'b1;
        req_a = 32'd5; req_b = 32'd7; req_op = ALUOP_ADD; req_tag = 4'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        check("t1_latency", n, 3);
        check("t1_c", rsp_c, 32'd12);
        check("t1_tag", rsp_tag, 3);
        drain();

        send(32'd9, 32'd9, ALUOP_SUB, 4'd1);
        send(32'd3, 32'd10, ALUOP_SUB, 4'd2);
        drain();
        check("t2_last_c", rsp_c, 32'hFFFF_FFF9);

        op_save = alu_op;
        a_save  = alu_a;
        send(32'd1, 32'd2, 5'b00010, 4'd4);
        drain();
        check("err_alu_op_held", alu_op, op_save);
        check("err_alu_a_held", alu_a, a_save);

        send(32'h7FFF_FFFF, 32'd1, ALUOP_ADD, 4'd5);
        drain();
        check("t3_wrap_c", rsp_c, 32'h8000_0000);

        // Fill: one op in flight plus DEPTH queued
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_a = $urandom; req_b = $urandom; req_op = ALUOP_ADD; req_tag = 4'(acc);
            @(negedge clk);
            if (!req_ready) break;
            acc++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("t4_accepted", acc, DEPTH + 1);
        check("t4_req_ready_low", req_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();

        // Randomized mix with random back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            send(ra, ($urandom_range(0, 3) == 0) ? ra : 32'($urandom),
                 ($urandom_range(0, 7) == 0) ? 5'($urandom_range(2, 31)) : 5'($urandom_range(0, 1)),
                 4'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rnd_ready = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Reset while the ALU op is in WAIT
        send(32'd100, 32'd23, ALUOP_ADD, 4'd9);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1 check_all_zero("t5_rst");
        q.delete();
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid) n++; end
        check("t5_no_rsp", n, 0);
        @(posedge clk); #1;
        send(32'd40, 32'd2, ALUOP_ADD, 4'd6);
        drain();
        check("t5_after_c", rsp_c, 32'd42);

`ifdef ALU_DRV_SELFCHECK_EN
        alu_fault = 1'b1;
        send(32'd20, 32'd22, ALUOP_ADD, 4'd7);
        drain();
        check("t6_mismatch_set", rsp_mismatch, 1);
        alu_fault = 1'b0;
        send(32'd20, 32'd22, ALUOP_ADD, 4'd8);
        drain();
        check("t6_mismatch_clr", rsp_mismatch, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
